// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module   : dmem_responder_if
// Brief    : MEM-stage load/store handshake bundle between pipeline and dmem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] MemRDM;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  MemRDM, ack, stall, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output MemRDM, ack, stall, err
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data memory responder with stall/ack handshake.
//            Define DMEM_FAST_WRITE_EN to let stores bypass the WAIT phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);
    localparam int         C_DEPTH    = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_err;

    logic [31:0] mem [0:C_DEPTH-1];

    logic              w_lat_in_rng;
    logic              w_req_in_rng;
    logic              w_access;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [31:0]       w_mem_data;
    logic [3:0]        w_mem_be;
    logic              w_unused_ok;

    assign w_lat_in_rng = (r_addr[31:ADDR_W+2] == '0);
    assign w_req_in_rng = (bus.addr[31:ADDR_W+2] == '0);
    assign w_access     = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_unused_ok  = ^{r_addr[1:0], bus.addr[1:0], w_req_in_rng};

    // Write port sources either the latched request or, for fast stores, the live bus.
    always_comb begin
        w_mem_we   = !reset && w_access && r_we && w_lat_in_rng;
        w_mem_idx  = r_addr[ADDR_W+1:2];
        w_mem_data = r_wdata;
        w_mem_be   = r_be;
`ifdef DMEM_FAST_WRITE_EN
        if ((r_state == S_IDLE) && bus.req && bus.we) begin
            w_mem_we   = !reset && w_req_in_rng;
            w_mem_idx  = bus.addr[ADDR_W+1:2];
            w_mem_data = bus.wdata;
            w_mem_be   = bus.be;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mem_be[i]) begin
                    mem[w_mem_idx][8*i +: 8] <= w_mem_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_be    <= bus.be;
                        r_cnt   <= C_CNT_INIT;
                        r_state <= S_WAIT;
`ifdef DMEM_FAST_WRITE_EN
                        if (bus.we) begin
                            r_state <= S_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= !w_req_in_rng;
                        end
`endif
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_DONE;
                        r_ack   <= 1'b1;
                        r_err   <= !w_lat_in_rng;
                        if (!r_we) begin
                            r_rdata <= w_lat_in_rng ? mem[r_addr[ADDR_W+1:2]] : 32'd0;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.MemRDM = r_rdata;
    assign bus.ack    = r_ack;
    assign bus.err    = r_err;
    assign bus.stall  = !reset && (((r_state == S_IDLE) && bus.req) || (r_state == S_WAIT));

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage load/store interface.
- Accepts one request at a time from the MEM stage (initiator), models a fixed multi-cycle access latency, and performs byte-enabled writes or full-word reads.
- Returns the read word on MemRDM for capture into the MEM/WB register.
- Drives a stall output that the hazard logic uses to hold pipeline registers (their en inputs) until the access completes.

Parameters:
- ADDR_W, 10, word-address width; storage is 2^ADDR_W 32-bit words.
- LATENCY, 2, number of WAIT cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all control state
- req  input  1  MEM stage requests an access this cycle (sampled only in IDLE)
- we  input  1  1 = store, 0 = load
- addr  input  32  byte address; word index = addr[ADDR_W+1:2]
- wdata  input  32  store data, already lane-aligned by MEM stage
- be  input  4  byte enables for store; be[i] writes wdata[8i+7:8i]
- MemRDM  output  32  registered read data
- ack  output  1  one-cycle pulse: access complete, MemRDM valid
- stall  output  1  hold the pipeline while high
- err  output  1  registered; set with ack when the address is out of range

Behaviour:
- Reset (async): state = IDLE, cnt = 0, MemRDM = 0, ack = 0, err = 0, latched request cleared. stall is forced 0 while reset is high. Memory array contents are not reset.
- States: IDLE, WAIT, DONE.
- IDLE:
  - stall = req (combinational).
  - On posedge with req = 1: latch we/addr/wdata/be, cnt <= LATENCY-1, go to WAIT.
  - req = 0: stay in IDLE.
- WAIT:
  - stall = 1.
  - Each posedge with cnt != 0: cnt <= cnt-1.
  - Posedge with cnt == 0: perform the access and go to DONE.
  - WAIT therefore lasts exactly LATENCY cycles.
- Access (performed at the WAIT->DONE edge):
  - Store: for each i with be[i] = 1, write the byte lane; MemRDM unchanged.
  - Load: MemRDM <= mem[index]. be is ignored; the WB stage performs byte/half selection and extension.
  - If addr[31:ADDR_W+2] != 0: no write, MemRDM <= 0, err <= 1.
  - Otherwise err <= 0.
- DONE:
  - stall = 0, ack = 1 for exactly one cycle.
  - The pipeline advances on this edge; next state is IDLE unconditionally.
  - req is ignored in DONE. The next request is sampled in the following IDLE cycle.
- Latency: a request seen in IDLE at cycle t gives ack at cycle t+LATENCY+1. stall is high for LATENCY+1 cycles.
- Changes to we/addr/wdata/be after acceptance have no effect (the request is latched).
- A store with be = 4'b0000 is a legal no-op that completes the full handshake.
- Reset asserted in WAIT: the pending access is abandoned with no memory write; the block returns to IDLE immediately.
- MemRDM holds its last value except on a load completion or reset.

Optional Feature:
- Macro: DMEM_FAST_WRITE_EN.
- Defined: stores skip WAIT. The IDLE->DONE transition performs the write at the acceptance edge; stall is high for 1 cycle and ack arrives at t+1. Loads are unchanged. Out-of-range stores still set err and suppress the write.
- Undefined: stores and loads share the identical LATENCY path.

Test Plan:
- Reset then idle: reset pulse, req = 0 -> MemRDM = 0, ack = 0, stall = 0, err = 0.
- Store then load, LATENCY = 2: store addr 0x10, wdata 0xDEADBEEF, be = 4'hF at cycle 0 -> stall high cycles 0-2, ack cycle 3. Then load addr 0x10 -> MemRDM = 0xDEADBEEF with ack 3 cycles after acceptance.
- Byte enables: store 0x11223344 be = 4'hF, then store 0xAABBCCDD be = 4'b0101 to the same word -> load returns 0x11BB33DD.
- Out of range: load addr 0x00010000 (ADDR_W = 10) -> ack with err = 1, MemRDM = 0. A store to the same address leaves memory untouched (verified by readback via its aliased index).
- Reset mid-WAIT: store 0x55 be = 4'h1 to addr 0x20, assert reset in the 2nd WAIT cycle -> state IDLE, stall = 0, no ack; later load of 0x20 returns the prior value.
- DMEM_FAST_WRITE_EN defined: store accepted at cycle 0 -> stall high only cycle 0, ack at cycle 1. A load at cycle 2 still acks at cycle 5.
